// File: rtl/palindrome_pkg.sv
// Shared types and constants for the palindrome checker.
package palindrome_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned MAX_UNITS      = DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        MODE_BIT    = 2'b00,
        MODE_NIBBLE = 2'b01,
        MODE_BYTE   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Width in bits of one unit; 0 for the reserved encoding.
    function automatic int unsigned unit_width(input mode_e mode);
        case (mode)
            MODE_BIT:    return 1;
            MODE_NIBBLE: return 4;
            MODE_BYTE:   return 8;
            default:     return 0;
        endcase
    endfunction

endpackage

// File: rtl/palindrome_unit_sel.sv
// Selects unit[idx] from a word for the given unit size, zero-extended to 8 bits.
module palindrome_unit_sel
    import palindrome_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IDX_W      = 5
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  mode_e                 i_mode,
    input  logic [IDX_W-1:0]      i_idx,
    output logic [7:0]            o_unit
);

    int unsigned w_shift;
    logic [7:0]  w_raw;

    // Shift the addressed unit down to bit 0, then mask to the unit size.
    always_comb begin
        w_shift = 32'(i_idx) * unit_width(i_mode);
        w_raw   = 8'(i_word >> w_shift);
        o_unit  = '0;
        case (i_mode)
            MODE_BIT:    o_unit = {7'b0, w_raw[0]};
            MODE_NIBBLE: o_unit = {4'b0, w_raw[3:0]};
            MODE_BYTE:   o_unit = w_raw;
            default:     o_unit = '0;
        endcase
    end

endmodule

// File: rtl/palindrome_check_core.sv
// Sequential palindrome checker with two converging pointers and saturating statistics.
module palindrome_check_core
    import palindrome_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            mode_in,
    input  logic [5:0]            len_in,
    input  logic                  clr_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  is_pal,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  check_cnt,
    output logic [CNT_WIDTH-1:0]  pal_cnt
);

    localparam int unsigned PW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_e                r_state, w_next_state;
    logic [DATA_WIDTH-1:0] r_data;
    mode_e                 r_mode;
    logic [PW-1:0]         r_lo, r_hi;
    logic                  r_is_pal, r_err;
    logic [CNT_WIDTH-1:0]  r_check_cnt, r_pal_cnt;

    mode_e                 w_req_mode;
    int unsigned           w_full_units, w_req_units;
    logic                  w_req_illegal;
    logic                  w_accept, w_pass, w_fail;
    logic [7:0]            w_unit_lo, w_unit_hi;

    palindrome_unit_sel #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(PW)) u_sel_lo (
        .i_word (r_data),
        .i_mode (r_mode),
        .i_idx  (r_lo),
        .o_unit (w_unit_lo)
    );

    palindrome_unit_sel #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(PW)) u_sel_hi (
        .i_word (r_data),
        .i_mode (r_mode),
        .i_idx  (r_hi),
        .o_unit (w_unit_hi)
    );

    // Decode the incoming request: effective unit count and legality.
    always_comb begin
        w_req_mode = mode_e'(mode_in);
        case (w_req_mode)
            MODE_BIT:    w_full_units = DATA_WIDTH;
            MODE_NIBBLE: w_full_units = DATA_WIDTH / 4;
            MODE_BYTE:   w_full_units = DATA_WIDTH / 8;
            default:     w_full_units = 0;
        endcase
        w_req_units   = (len_in == 6'd0) ? w_full_units : 32'(len_in);
        w_req_illegal = (w_req_mode == MODE_RSVD) || (w_req_units > w_full_units);
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic and per-cycle pair verdict.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_pass       = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_req_illegal ? ST_DONE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_lo >= r_hi) begin
                    w_pass       = 1'b1;
                    w_next_state = ST_DONE;
                end else if (w_unit_lo != w_unit_hi) begin
                    w_fail       = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, pointer walk and result/error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data   <= '0;
            r_mode   <= MODE_BIT;
            r_lo     <= '0;
            r_hi     <= '0;
            r_is_pal <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_data   <= data_in;
            r_mode   <= w_req_mode;
            r_lo     <= '0;
            r_hi     <= PW'(w_req_units - 1);
            r_is_pal <= 1'b0;
            r_err    <= w_req_illegal;
        end else if (r_state == ST_CHECK) begin
            if (w_pass) begin
                r_is_pal <= 1'b1;
            end else if (!w_fail) begin
                r_lo <= r_lo + PW'(1);
                r_hi <= r_hi - PW'(1);
            end
        end
    end

    // Saturating statistics; a clear wins over a coincident increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_check_cnt <= '0;
            r_pal_cnt   <= '0;
        end else if (clr_cnt) begin
            r_check_cnt <= '0;
            r_pal_cnt   <= '0;
        end else if (w_pass || w_fail) begin
            if (r_check_cnt != '1) r_check_cnt <= r_check_cnt + CNT_WIDTH'(1);
            if (w_pass && (r_pal_cnt != '1)) r_pal_cnt <= r_pal_cnt + CNT_WIDTH'(1);
        end
    end

    assign busy      = (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign is_pal    = r_is_pal;
    assign err       = r_err;
    assign check_cnt = r_check_cnt;
    assign pal_cnt   = r_pal_cnt;

endmodule

// File: tb/tb_palindrome_check_core.sv
// Self-checking bench for palindrome_check_core: vector table, corner sequences, random traffic.
module tb_palindrome_check_core;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [1:0]  mode_in;
    logic [5:0]  len_in;
    logic        clr_cnt;
    logic        busy, done, is_pal, err;
    logic [CW-1:0] check_cnt, pal_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_check_cnt = 0;
    int exp_pal_cnt   = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [5:0]  len;
        logic [31:0] data;
        bit          exp_err;
        bit          exp_pal;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    palindrome_check_core #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .mode_in   (mode_in),
        .len_in    (len_in),
        .clr_cnt   (clr_cnt),
        .busy      (busy),
        .done      (done),
        .is_pal    (is_pal),
        .err       (err),
        .check_cnt (check_cnt),
        .pal_cnt   (pal_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: split the word into units, compare mirrored pairs.
    function automatic void model(input logic [1:0] m, input logic [5:0] l, input logic [31:0] d,
                                  output bit e, output bit p, output int cyc);
        int w, full, n;
        longint dd, mask;
        longint u[$];
        e = 0; p = 0; cyc = 0;
        case (m)
            2'd0: w = 1;
            2'd1: w = 4;
            2'd2: w = 8;
            default: w = 0;
        endcase
        if (w == 0) begin e = 1; return; end
        full = 32 / w;
        n = (l == 0) ? full : int'(l);
        if (n > full) begin e = 1; return; end
        dd = longint'(d);
        mask = (longint'(1) << w) - 1;
        for (int i = 0; i < n; i++) u.push_back((dd >> (i * w)) & mask);
        p = 1;
        cyc = n / 2 + 1;
        for (int k = 0; k < n / 2; k++) begin
            if (u[k] != u[n - 1 - k]) begin
                p = 0;
                cyc = k + 1;
                break;
            end
        end
    endfunction

    task automatic issue(input logic [1:0] m, input logic [5:0] l, input logic [31:0] d);
        mode_in = m; len_in = l; data_in = d; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit timeout);
        cyc = 0; timeout = 1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin timeout = 0; break; end
            if (busy) cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] m, input logic [5:0] l,
                                 input logic [31:0] d, input bit e, input bit p, input int c);
        int cyc;
        bit to;
        issue(m, l, d);
        if (!e) begin
            chk($sformatf("%s.busy_after_start", tag), busy, 1);
            chk($sformatf("%s.err_cleared", tag), err, 0);
        end
        wait_done(cyc, to);
        chk($sformatf("%s.timeout", tag), to, 0);
        chk($sformatf("%s.cycles", tag), cyc, c);
        chk($sformatf("%s.busy_at_done", tag), busy, 0);
        chk($sformatf("%s.err", tag), err, e);
        chk($sformatf("%s.is_pal", tag), is_pal, e ? 1'b0 : p);
        if (!e) begin
            if (exp_check_cnt < CMAX) exp_check_cnt++;
            if (p && exp_pal_cnt < CMAX) exp_pal_cnt++;
        end
        chk($sformatf("%s.check_cnt", tag), check_cnt, exp_check_cnt);
        chk($sformatf("%s.pal_cnt", tag), pal_cnt, exp_pal_cnt);
        @(posedge clock); #1;
        chk($sformatf("%s.done_one_cycle", tag), done, 0);
    endtask

    initial begin
        int dones, cyc;
        bit to, e, p;
        int c, w, full, n;
        logic [1:0] m;
        logic [5:0] l;
        logic [31:0] d;
        longint dd, mask, u;

        reset = 1'b1; start = 1'b0; clr_cnt = 1'b0;
        data_in = '0; mode_in = '0; len_in = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.is_pal", is_pal, 0);
        chk("reset.err", err, 0);
        chk("reset.check_cnt", check_cnt, 0);
        chk("reset.pal_cnt", pal_cnt, 0);

        vecs.push_back('{2'd0, 6'd0,  32'h8000_0001, 1'b0, 1'b1, 17});
        vecs.push_back('{2'd2, 6'd0,  32'h1234_3412, 1'b0, 1'b1, 3});
        vecs.push_back('{2'd2, 6'd0,  32'h1234_5678, 1'b0, 1'b0, 1});
        vecs.push_back('{2'd1, 6'd3,  32'h0000_0121, 1'b0, 1'b1, 2});
        vecs.push_back('{2'd1, 6'd4,  32'h0000_1221, 1'b0, 1'b1, 3});
        vecs.push_back('{2'd1, 6'd4,  32'h0000_1231, 1'b0, 1'b0, 2});
        vecs.push_back('{2'd3, 6'd0,  32'h0000_0000, 1'b1, 1'b0, 0});
        vecs.push_back('{2'd2, 6'd5,  32'h1234_5678, 1'b1, 1'b0, 0});
        vecs.push_back('{2'd2, 6'd4,  32'h0000_0000, 1'b0, 1'b1, 3});
        vecs.push_back('{2'd0, 6'd1,  32'hFFFF_FFFE, 1'b0, 1'b1, 1});
        vecs.push_back('{2'd1, 6'd0,  32'h1234_4321, 1'b0, 1'b1, 5});
        vecs.push_back('{2'd0, 6'd33, 32'h0000_0000, 1'b1, 1'b0, 0});
        vecs.push_back('{2'd0, 6'd32, 32'h0000_FFFF, 1'b0, 1'b0, 1});
        vecs.push_back('{2'd2, 6'd1,  32'h0000_00AB, 1'b0, 1'b1, 1});

        foreach (vecs[i])
            run_and_check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].len, vecs[i].data,
                          vecs[i].exp_err, vecs[i].exp_pal, vecs[i].exp_cyc);

        // Start pulses during CHECK and during the done cycle must be ignored.
        issue(2'd0, 6'd0, 32'h8000_0001);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) dones++;
            start = (i == 2) || (i == 5) || done;
            mode_in = 2'd3;
            @(posedge clock); #1;
        end
        start = 1'b0;
        if (exp_check_cnt < CMAX) exp_check_cnt++;
        if (exp_pal_cnt < CMAX) exp_pal_cnt++;
        chk("ignore.done_pulses", dones, 1);
        chk("ignore.idle_after", busy, 0);
        chk("ignore.is_pal", is_pal, 1);
        chk("ignore.err", err, 0);
        chk("ignore.check_cnt", check_cnt, exp_check_cnt);
        chk("ignore.pal_cnt", pal_cnt, exp_pal_cnt);

        // Clear coincident with the DONE entry of a 3-cycle check.
        issue(2'd2, 6'd0, 32'h1234_3412);
        @(posedge clock); #1;
        @(posedge clock); #1;
        clr_cnt = 1'b1;
        @(posedge clock); #1;
        clr_cnt = 1'b0;
        exp_check_cnt = 0; exp_pal_cnt = 0;
        chk("clr.done", done, 1);
        chk("clr.is_pal", is_pal, 1);
        chk("clr.check_cnt", check_cnt, 0);
        chk("clr.pal_cnt", pal_cnt, 0);
        @(posedge clock); #1;

        // Bring the counters up, then reset on the third CHECK cycle.
        run_and_check("pre_rst", 2'd2, 6'd0, 32'h1234_3412, 1'b0, 1'b1, 3);
        issue(2'd0, 6'd0, 32'h8000_0001);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst.in_check", busy, 1);
        reset = 1'b1;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.check_cnt", check_cnt, 0);
        chk("rst.pal_cnt", pal_cnt, 0);
        exp_check_cnt = 0; exp_pal_cnt = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            if (done || busy) dones++;
        end
        chk("rst.no_activity", dones, 0);
        run_and_check("post_rst", 2'd0, 6'd0, 32'h8000_0001, 1'b0, 1'b1, 17);

        // Random requests against the reference model; one idle clear midway.
        for (int i = 0; i < 60; i++) begin
            if (i == 30) begin
                clr_cnt = 1'b1;
                @(posedge clock); #1;
                clr_cnt = 1'b0;
                exp_check_cnt = 0; exp_pal_cnt = 0;
                chk("rand.clr_check_cnt", check_cnt, 0);
                chk("rand.clr_pal_cnt", pal_cnt, 0);
            end
            m = 2'($urandom_range(0, 3));
            w = (m == 2'd0) ? 1 : (m == 2'd1) ? 4 : (m == 2'd2) ? 8 : 0;
            full = (w != 0) ? 32 / w : 0;
            if (w == 0 || $urandom_range(0, 3) == 0) l = 6'($urandom_range(0, 40));
            else l = 6'($urandom_range(0, full));
            d = $urandom;
            if (w != 0 && $urandom_range(0, 1) == 1) begin
                n = (l == 0) ? full : int'(l);
                if (n <= full) begin
                    dd = longint'(d);
                    mask = (longint'(1) << w) - 1;
                    for (int k = 0; k < n / 2; k++) begin
                        u = (dd >> (k * w)) & mask;
                        dd = dd & ~(mask << ((n - 1 - k) * w));
                        dd = dd | (u << ((n - 1 - k) * w));
                    end
                    d = 32'(dd);
                end
            end
            model(m, l, d, e, p, c);
            run_and_check($sformatf("rand%0d", i), m, l, d, e, p, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
